pc_fetch_stage: RTL and testbench

- Program-counter and instruction-fetch stage.
- Sits directly downstream of MUX_C. It consumes output_muxc as the branch/jump target, registers the next PC, and fetches from instruction memory over a one-outstanding req/ack handshake.
- Produces the instruction register and the pipelined PC_1/PC_2 values used by decode and by branch-address formation.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/pc_fetch_stage_pc_reg.sv | 38 +++
 rtl/pc_fetch_stage.sv | 154 +++++++++++++++
 tb/tb_pc_fetch_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the PC / instruction-fetch stage.
package fetch_pkg;

   localparam int          DATA_W_DEF   = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      ISSUE    = 2'd0,
      WAIT_ACK = 2'd1,
      DROP     = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_stage_pc_reg.sv
// Program-counter register: reset > redirect load > increment > hold.
module pc_reg
   import fetch_pkg::*;
#(
   parameter int                DATA_W   = DATA_W_DEF,
   parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [DATA_W-1:0] target_i,
   input  logic              inc_i,
   output logic [DATA_W-1:0] pc_o
);

   logic [DATA_W-1:0] pc_q;
   logic [DATA_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = target_i;
      end else if (inc_i) begin
         pc_d = pc_q + DATA_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// PC / instruction-fetch stage with one-outstanding imem handshake.
// Optional redirect statistics counters under FETCH_BRANCH_STATS_EN.
module pc_fetch_stage
   import fetch_pkg::*;
#(
   parameter int                DATA_W   = DATA_W_DEF,
   parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect,
   input  logic [DATA_W-1:0] output_muxc,
   input  logic              stall,
   output logic              imem_req,
   output logic [DATA_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_data,
   output logic [DATA_W-1:0] ir_out,
   output logic              ir_valid,
   output logic [DATA_W-1:0] PC_1,
   output logic [DATA_W-1:0] PC_2
`ifdef FETCH_BRANCH_STATS_EN
   ,
   output logic [31:0]       branch_count,
   output logic [31:0]       flush_count
`endif
);

   fetch_state_e      state_q, state_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              vld_q, vld_d;
   logic [DATA_W-1:0] pc1_q, pc1_d;
   logic [DATA_W-1:0] pc2_q, pc2_d;
   logic [DATA_W-1:0] pc_q;
   logic              take_ack;
   logic              pc_inc;

   pc_reg #(
      .DATA_W   (DATA_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .reset    (reset),
      .load_i   (redirect),
      .target_i (output_muxc),
      .inc_i    (pc_inc),
      .pc_o     (pc_q)
   );

   assign take_ack = (state_q == WAIT_ACK) && imem_ack;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ir_d    = ir_q;
      vld_d   = vld_q;
      pc1_d   = pc1_q;
      pc2_d   = pc2_q;
      pc_inc  = 1'b0;

      // The request address is latched at issue so it stays put even if a
      // redirect moves the PC while the fetch is still outstanding.
      unique case (state_q)
         ISSUE: begin
            if (redirect || !vld_q || !stall) begin
               state_d = WAIT_ACK;
               addr_d  = redirect ? output_muxc : pc_q;
            end
         end
         WAIT_ACK: begin
            if (imem_ack) begin
               state_d = ISSUE;
            end else if (redirect) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (imem_ack) begin
               state_d = ISSUE;
            end
         end
         default: state_d = ISSUE;
      endcase

      if (redirect) begin
         vld_d = 1'b0;
      end else if (take_ack) begin
         ir_d   = imem_data;
         vld_d  = 1'b1;
         pc1_d  = pc_q + DATA_W'(1);
         pc_inc = 1'b1;
      end else if (vld_q && !stall) begin
         vld_d = 1'b0;
         pc2_d = pc1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ISSUE;
         addr_q  <= RESET_PC;
         ir_q    <= '0;
         vld_q   <= 1'b0;
         pc1_q   <= '0;
         pc2_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         ir_q    <= ir_d;
         vld_q   <= vld_d;
         pc1_q   <= pc1_d;
         pc2_q   <= pc2_d;
      end
   end

   assign imem_req  = (state_q != ISSUE);
   assign imem_addr = addr_q;
   assign ir_out    = ir_q;
   assign ir_valid  = vld_q;
   assign PC_1      = pc1_q;
   assign PC_2      = pc2_q;

`ifdef FETCH_BRANCH_STATS_EN
   logic [31:0] branch_cnt_q;
   logic [31:0] flush_cnt_q;
   logic        flush_hit;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // A flush is one event whether it kills ir_out, an in-flight fetch, or both.
   assign flush_hit = redirect && (vld_q || (state_q != ISSUE));

   always_ff @(posedge clk) begin
      if (reset) begin
         branch_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         if (redirect) begin
            branch_cnt_q <= sat_inc(branch_cnt_q);
         end
         if (flush_hit) begin
            flush_cnt_q <= sat_inc(flush_cnt_q);
         end
      end
   end

   assign branch_count = branch_cnt_q;
   assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage; expectations are hand-computed per step.
// Stats counters are checked when FETCH_BRANCH_STATS_EN is defined.
module tb_pc_fetch_stage;

   logic        clk;
   logic        reset;
   logic        redirect;
   logic [31:0] output_muxc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] ir_out;
   logic        ir_valid;
   logic [31:0] PC_1;
   logic [31:0] PC_2;
`ifdef FETCH_BRANCH_STATS_EN
   logic [31:0] branch_count;
   logic [31:0] flush_count;
`endif

   int checks;
   int errors;

   pc_fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .output_muxc (output_muxc),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .ir_out      (ir_out),
      .ir_valid    (ir_valid),
      .PC_1        (PC_1),
      .PC_2        (PC_2)
`ifdef FETCH_BRANCH_STATS_EN
      ,
      .branch_count (branch_count),
      .flush_count  (flush_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Waits one cycle with the request pending, then acks it with data d.
   task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc2_exp);
      check("req_pending", {31'd0, imem_req}, 32'd1);
      check("addr_pending", imem_addr, a);
      step();
      check("req_held", {31'd0, imem_req}, 32'd1);
      check("addr_held", imem_addr, a);
      check("vld_wait", {31'd0, ir_valid}, 32'd0);
      imem_ack  = 1'b1;
      imem_data = d;
      step();
      imem_ack  = 1'b0;
      check("vld_after_ack", {31'd0, ir_valid}, 32'd1);
      check("ir_after_ack", ir_out, d);
      check("pc1_after_ack", PC_1, a + 32'd1);
      check("pc2_after_ack", PC_2, pc2_exp);
      check("req_after_ack", {31'd0, imem_req}, 32'd0);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      redirect    = 1'b0;
      output_muxc = 32'd0;
      stall       = 1'b0;
      imem_ack    = 1'b0;
      imem_data   = 32'd0;

      step();
      step();
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_vld", {31'd0, ir_valid}, 32'd0);
      check("rst_ir", ir_out, 32'd0);
      check("rst_pc1", PC_1, 32'd0);
      check("rst_pc2", PC_2, 32'd0);
      reset = 1'b0;

      // sequential fetch 0,1,2 with data addr*4
      step();
      do_fetch(32'd0, 32'd0, 32'd0);
      step();
      check("pc2_consume0", PC_2, 32'd1);
      do_fetch(32'd1, 32'd4, 32'd1);
      step();
      check("pc2_consume1", PC_2, 32'd2);
      do_fetch(32'd2, 32'd8, 32'd2);

      // stall holds the output slot and blocks new requests
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_vld", {31'd0, ir_valid}, 32'd1);
         check("stall_ir", ir_out, 32'd8);
         check("stall_pc1", PC_1, 32'd3);
         check("stall_pc2", PC_2, 32'd2);
         check("stall_req", {31'd0, imem_req}, 32'd0);
      end
      stall = 1'b0;
      step();
      check("resume_pc2", PC_2, 32'd3);
      check("resume_vld", {31'd0, ir_valid}, 32'd0);
      do_fetch(32'd3, 32'd12, 32'd3);
      step();
      do_fetch(32'd4, 32'd16, 32'd4);
      step();
      check("wait5_req", {31'd0, imem_req}, 32'd1);
      check("wait5_addr", imem_addr, 32'd5);

      // redirect to 500 while fetch of 5 outstanding
      redirect    = 1'b1;
      output_muxc = 32'd500;
      step();
      redirect = 1'b0;
      check("drop_req", {31'd0, imem_req}, 32'd1);
      check("drop_addr", imem_addr, 32'd5);
      check("drop_vld", {31'd0, ir_valid}, 32'd0);
      step();
      check("drop_vld2", {31'd0, ir_valid}, 32'd0);
      imem_ack  = 1'b1;
      imem_data = 32'hDEAD;
      step();
      imem_ack = 1'b0;
      check("dead_vld", {31'd0, ir_valid}, 32'd0);
      check("dead_ir", ir_out, 32'd16);
      check("dead_req", {31'd0, imem_req}, 32'd0);
      step();
      check("tgt500_addr", imem_addr, 32'd500);
      do_fetch(32'd500, 32'h1234, 32'd5);
      step();
      check("wait501_addr", imem_addr, 32'd501);

      // redirect and ack in the same cycle
      redirect    = 1'b1;
      output_muxc = 32'd900;
      imem_ack    = 1'b1;
      imem_data   = 32'hBEEF;
      step();
      redirect = 1'b0;
      imem_ack = 1'b0;
      check("same_vld", {31'd0, ir_valid}, 32'd0);
      check("same_pc1", PC_1, 32'd501);
      check("same_req", {31'd0, imem_req}, 32'd0);
      step();
      check("tgt900_req", {31'd0, imem_req}, 32'd1);
      check("tgt900_addr", imem_addr, 32'd900);

      // redirect to all-ones; drain fetch of 900 first
      redirect    = 1'b1;
      output_muxc = 32'hFFFF_FFFF;
      step();
      redirect = 1'b0;
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      check("wrapdrop_vld", {31'd0, ir_valid}, 32'd0);
      step();
      do_fetch(32'hFFFF_FFFF, 32'd77, 32'd501);
      check("wrap_pc1", PC_1, 32'd0);
      step();
      check("wrap_addr", imem_addr, 32'd0);
      check("wrap_req", {31'd0, imem_req}, 32'd1);
`ifdef FETCH_BRANCH_STATS_EN
      check("branch_cnt", branch_count, 32'd3);
      check("flush_cnt", flush_count, 32'd3);
`endif

      // reset mid WAIT_ACK, then a stale ack
      reset = 1'b1;
      step();
      reset     = 1'b0;
      imem_ack  = 1'b1;
      imem_data = 32'd99;
      check("rst2_req", {31'd0, imem_req}, 32'd0);
      check("rst2_vld", {31'd0, ir_valid}, 32'd0);
      check("rst2_ir", ir_out, 32'd0);
      check("rst2_pc1", PC_1, 32'd0);
      check("rst2_pc2", PC_2, 32'd0);
`ifdef FETCH_BRANCH_STATS_EN
      check("rst2_branch", branch_count, 32'd0);
      check("rst2_flush", flush_count, 32'd0);
`endif
      step();
      imem_ack = 1'b0;
      check("stale_vld", {31'd0, ir_valid}, 32'd0);
      check("post_rst_addr", imem_addr, 32'd0);
      do_fetch(32'd0, 32'hAB, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
